// File: rtl/tx_clock_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tx_clock_scheduler
//  Description : Transmit timing scheduler. Aligns start/stop of transmission
//                to divider frame boundaries, issues symbol strobes at a
//                selectable sub-rate, counts frames and manages rate changes
//                that take effect only on frame boundaries while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_clock_scheduler #(
   parameter int MOD  = 8,
   parameter int BITS = $clog2(MOD)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [BITS-1:0] count,
   input  logic            start,
   input  logic            stop,
   input  logic [1:0]      rate_sel,
   input  logic            rate_req,
   output logic            rate_ack,
   output logic [1:0]      active_rate,
   output logic            strobe,
   output logic            frame_start,
   output logic            busy,
   output logic [7:0]      frame_cnt,
   output logic            overrun
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Last count value of a frame; MOD is a power of two so this is all ones.
   localparam logic [BITS-1:0] C_LAST = BITS'(MOD - 1);

   // FSM and timing outputs
   state_t          state_q;
   logic            busy_q;
   logic            strobe_q;
   logic            frame_start_q;
   logic [7:0]      frame_cnt_q;

   // Rate management
   logic [1:0]      active_rate_q;
   logic [1:0]      active_rate_d;
   logic            rate_ack_q;
   logic            rate_ack_d;
   logic            pend_q;
   logic            pend_d;
   logic [1:0]      pend_rate_q;
   logic [1:0]      pend_rate_d;
   logic            overrun_q;
   logic            overrun_d;

   // Decoded conditions for the current input cycle
   logic            w_boundary;
   logic            w_symbol;
   logic            w_arm_now;
   logic            w_apply_pt;
   logic [BITS-1:0] w_mask;

   // Symbol mask N-1 for the rate currently in force
   always_comb begin
      w_mask = '0;
      case (active_rate_q)
         2'b00:   w_mask = BITS'(0);
         2'b01:   w_mask = BITS'(1);
         2'b10:   w_mask = BITS'(3);
         2'b11:   w_mask = BITS'(7);
         default: w_mask = '0;
      endcase
   end

   assign w_boundary = (count == C_LAST);
   assign w_symbol   = ((count & w_mask) == w_mask);
   assign w_arm_now  = (state_q == ST_IDLE) && start && !stop;

   // Points where a pending rate may be committed: every boundary while busy,
   // plus an ARM abort so no pending change is ever carried back into IDLE.
   assign w_apply_pt = (state_q != ST_IDLE) &&
                       (w_boundary || ((state_q == ST_ARM) && stop));

   // Next-state logic for active rate, pending slot, acknowledge and overrun
   always_comb begin
      active_rate_d = active_rate_q;
      rate_ack_d    = 1'b0;
      pend_d        = pend_q;
      pend_rate_d   = pend_rate_q;
      overrun_d     = overrun_q;

      if (state_q == ST_IDLE) begin
         // Nothing is being timed, so a change is safe to take at once.
         if (rate_req) begin
            active_rate_d = rate_sel;
            rate_ack_d    = 1'b1;
         end
         if (w_arm_now) begin
            overrun_d = 1'b0;
         end
      end else begin
         // A second request before the first is committed loses the first.
         if (rate_req && pend_q) begin
            overrun_d = 1'b1;
         end
         if (w_apply_pt && (rate_req || pend_q)) begin
            // A request arriving on the apply point is newest and wins.
            active_rate_d = rate_req ? rate_sel : pend_rate_q;
            rate_ack_d    = 1'b1;
            pend_d        = 1'b0;
         end else if (rate_req) begin
            pend_d      = 1'b1;
            pend_rate_d = rate_sel;
         end
      end
   end

   // Rate management registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         active_rate_q <= 2'b00;
         rate_ack_q    <= 1'b0;
         pend_q        <= 1'b0;
         pend_rate_q   <= 2'b00;
         overrun_q     <= 1'b0;
      end else begin
         active_rate_q <= active_rate_d;
         rate_ack_q    <= rate_ack_d;
         pend_q        <= pend_d;
         pend_rate_q   <= pend_rate_d;
         overrun_q     <= overrun_d;
      end
   end

   // Control FSM with registered busy, strobe, frame_start and frame counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         busy_q        <= 1'b0;
         strobe_q      <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= 8'd0;
      end else begin
         // Strobes follow the state of the cycle that saw the count value,
         // so the DRAIN boundary still yields its final strobe.
         strobe_q      <= ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && w_symbol;
         frame_start_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (w_arm_now) begin
                  state_q     <= ST_ARM;
                  busy_q      <= 1'b1;
                  frame_cnt_q <= 8'd0;
               end
            end

            ST_ARM: begin
               if (stop) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (w_boundary) begin
                  state_q       <= ST_RUN;
                  frame_start_q <= 1'b1;
                  frame_cnt_q   <= frame_cnt_q + 8'd1;
               end
            end

            ST_RUN: begin
               if (stop) begin
                  state_q <= ST_DRAIN;
               end
               // A frame opened on the same boundary as stop is drained out.
               if (w_boundary) begin
                  frame_start_q <= 1'b1;
                  frame_cnt_q   <= frame_cnt_q + 8'd1;
               end
            end

            ST_DRAIN: begin
               if (w_boundary) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rate_ack    = rate_ack_q;
   assign active_rate = active_rate_q;
   assign strobe      = strobe_q;
   assign frame_start = frame_start_q;
   assign busy        = busy_q;
   assign frame_cnt   = frame_cnt_q;
   assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: doc/tx_clock_scheduler.md
TX_CLOCK_SCHEDULER -- requirements
Module: tx_clock_scheduler

Interface
REQ-001 SHALL have parameter MOD, default 8, meaning the frame length in clock cycles of the upstream divider count (power of 2, >=8).
REQ-002 SHALL have parameter BITS, default $clog2(MOD), meaning the width of the count input.
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port count  input  BITS  free-running divider count from the clock generator, 0..MOD-1, wrapping.
REQ-006 SHALL have port start  input  1  level; request to begin transmit timing.
REQ-007 SHALL have port stop  input  1  level; request to end transmit timing.
REQ-008 SHALL have port rate_sel  input  2  requested rate: 00 = div1, 01 = div2, 10 = div4, 11 = div8.
REQ-009 SHALL have port rate_req  input  1  one-cycle pulse; load rate_sel as a rate change.
REQ-010 SHALL have port rate_ack  output  1  one-cycle pulse; the requested rate is now active.
REQ-011 SHALL have port active_rate  output  2  rate currently in use.
REQ-012 SHALL have port strobe  output  1  one-cycle symbol enable at the active rate.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse at each frame boundary while running.
REQ-014 SHALL have port busy  output  1  high in states ARM, RUN and DRAIN.
REQ-015 SHALL have port frame_cnt  output  8  number of completed frames since start, wrapping 255->0.
REQ-016 SHALL have port overrun  output  1  sticky flag; a pending rate change was overwritten.

Function
REQ-017 SHALL define the boundary cycle as any cycle with count==MOD-1, and N as 1, 2, 4 or 8 per active_rate.
REQ-018 SHALL implement states IDLE, ARM, RUN and DRAIN.
REQ-019 IDLE->ARM SHALL occur when start=1; ARM->RUN SHALL occur on a boundary cycle; RUN->DRAIN SHALL occur when stop=1; DRAIN->IDLE SHALL occur on a boundary cycle.
REQ-020 When start and stop are both 1 in IDLE, stop SHALL win and the block SHALL remain in IDLE.
REQ-021 In ARM, stop=1 SHALL return the block to IDLE with no strobe issued.
REQ-022 In RUN and DRAIN, strobe SHALL be 1 in the cycle after any input cycle where (count & (N-1))==N-1; latency is 1 cycle; strobe SHALL be 0 otherwise.
REQ-023 In RUN, frame_start SHALL be 1 in the cycle after each boundary cycle, including the ARM->RUN boundary.
REQ-024 frame_cnt SHALL increment on each frame_start and SHALL clear to 0 on the IDLE->ARM transition.
REQ-025 In IDLE, rate_req SHALL load active_rate immediately, with rate_ack=1 in the next cycle.
REQ-026 In ARM, RUN or DRAIN, rate_req SHALL latch rate_sel as pending and apply it at the next boundary cycle.
REQ-027 rate_ack SHALL be 1 in the cycle after the apply, and the new N SHALL govern strobes from the first cycle after the boundary.
REQ-028 If rate_req arrives while a change is pending, the new value SHALL replace the pending one, overrun SHALL set, and only one rate_ack SHALL be issued.
REQ-029 If rate_req coincides with a boundary cycle, the new value SHALL apply at that boundary.
REQ-030 overrun SHALL clear only on the IDLE->ARM transition or on reset.
REQ-031 A pending change still unapplied on DRAIN->IDLE SHALL apply on that transition, with rate_ack issued.
REQ-032 busy SHALL be registered and SHALL change in the same cycle as the state.

Reset
REQ-033 reset=0 SHALL asynchronously force state IDLE, active_rate=00, pending cleared, frame_cnt=0 and overrun=0.
REQ-034 reset=0 SHALL asynchronously force strobe, frame_start, rate_ack and busy to 0.
REQ-035 Release of reset SHALL be synchronous to clock; reset asserted mid-RUN SHALL abandon the frame with no trailing strobe or ack.

Verification
REQ-036 MOD=8, rate 11, start at count=3 -> first frame_start after count=7, strobe once per 8 cycles, busy=1.
REQ-037 Running at div1, rate_req with rate_sel=01 at count=2 -> rate_ack and div2 strobes only after the count=7 boundary.
REQ-038 Two rate_req pulses (10, then 11) before one boundary -> one rate_ack, active_rate=11, overrun=1.
REQ-039 stop in RUN at count=4 -> strobes continue through count=7, then IDLE with busy=0.
REQ-040 reset pulsed low for 5 ns mid-RUN -> all outputs 0 immediately, active_rate=00, state IDLE.
REQ-041 frame_cnt run for 256 frames -> wraps to 0 with no glitch on frame_start.
